kpn_split_scheduler: RTL and testbench
======================================

# kpn_split_scheduler

Sequencing controller for a KPN split node: pulls one token from the input FIFO and delivers a copy to each of two output FIFOs, honouring Kahn blocking-write semantics. It generates the FIFO read/write strobes the split datapath needs, holds the token until both consumers have accepted it, and exports token and stall counters for software-side monitoring.

## Interface
- DATA_WIDTH, 16, token width
- CNT_WIDTH, 16, width of token_count and stall_count

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  permits starting a new token; an in-flight token always completes
- in_empty  in  1  input FIFO empty flag
- in_data  in  DATA_WIDTH  input FIFO read data, valid the cycle after in_rd
- in_rd  out  1  input FIFO read strobe, one cycle per token
- out1_full, out2_full  in  1  output FIFO full flags
- out1_wr, out2_wr  out  1  output FIFO write strobes
- out1_data, out2_data  out  DATA_WIDTH  token copy presented to each output FIFO
- busy  out  1  high in every state except IDLE
- token_count  out  CNT_WIDTH  tokens fully delivered to both outputs, wraps
- stall_count  out  CNT_WIDTH  EMIT cycles blocked by a full output, saturates

## Operation
- FSM states: IDLE, FETCH, LATCH, EMIT.
- IDLE -> FETCH when enable && !in_empty; otherwise stay. Output full flags are not checked here.
- FETCH: in_rd = 1 for exactly this cycle. Always -> LATCH.
- LATCH: token_reg <= in_data; done1, done2 <= 0. Always -> EMIT.
- EMIT:
  - out1_wr = !done1 && !out1_full.
  - out2_wr = !done2 && !out2_full.
  - Each write sets its done flag at the clock edge.
  - Leave for IDLE when both outputs are complete after this cycle: (done1 || out1_wr) && (done2 || out2_wr).
  - On that exit, token_count increments and wraps modulo 2^CNT_WIDTH.
- The two outputs are independent. A full output never blocks delivery to the other, and no output receives a token twice.
- stall_count increments in any EMIT cycle where (!done1 && out1_full) || (!done2 && out2_full). It saturates at all-ones.
- Write and read strobes are decoded combinationally from state, done flags and full flags. out1_data and out2_data both equal token_reg.
- enable is sampled only in IDLE. Deasserting it mid-token does not abort delivery.
- Reset values (asynchronous, any state): state IDLE, token_reg 0, done flags 0, both counters 0. This gives in_rd = out1_wr = out2_wr = busy = 0 and out1_data = out2_data = 0.
- Reset mid-operation discards the held token. Partial delivery (one output written) is not replayed.

## Timing
- Best case with no stalls, in_rd in cycle T:
  - token captured at the edge ending T+1
  - out1_wr and out2_wr both high in T+2
  - back in IDLE at T+3
- Maximum throughput is one token per 4 cycles (IDLE, FETCH, LATCH, EMIT).
- Each full output extends EMIT by one cycle per blocked cycle. There is no timeout.
- Simultaneous release: if both fulls drop in the same EMIT cycle, both writes occur in that cycle and the FSM exits.
- in_empty rising after FETCH has no effect; the read has already been committed.

## Structure
- Shared package kpn_pkg holds:
  - state enum kpn_split_state_t (IDLE, FETCH, LATCH, EMIT, 2-bit)
  - KPN_DATA_WIDTH = 16, the default token width shared by all KPN nodes
- One sub-module, kpn_sat_counter (parameterised width, inc, clear, asynchronous rst_n), used for stall_count and reusable by other KPN schedulers.
- token_count is a plain wrapping counter kept inline.

## Test plan
- Reset then no traffic: in_empty = 1 and enable = 1 for 20 cycles -> busy, in_rd, out*_wr stay 0; counters stay 0.
- Single token: 16'd10 in the FIFO, fulls low -> in_rd one cycle; out1_wr and out2_wr high two cycles later with data 16'd10; token_count = 1; stall_count = 0.
- Back-to-back tokens 16'd10, 16'd50, 16'd90 -> each delivered to both outputs in order, in_rd pulses 4 cycles apart, token_count = 3.
- Hold out2_full high for 5 EMIT cycles with token 16'd50 -> out1_wr fires once immediately; out2_wr fires once when full drops; stall_count = 5; no duplicate write on out1.
- Assert rst_n = 0 during EMIT with out1 already written -> all outputs 0 immediately; state IDLE; counters 0; after release the next FIFO token is fetched normally.
- Deassert enable during EMIT, then drive counters to overflow: the token still completes; no further in_rd while enable = 0; token_count wraps from all-ones to 0; stall_count holds at all-ones.

Source files
------------

// File: rtl/kpn_pkg.sv
// kpn_pkg: shared types and defaults for KPN node schedulers.
package kpn_pkg;
  localparam int KPN_DATA_WIDTH = 16;
  typedef enum logic [1:0] {IDLE, FETCH, LATCH, EMIT} kpn_split_state_t;
endpackage

// File: rtl/kpn_sat_counter.sv
// kpn_sat_counter: saturating up-counter with synchronous clear.
module kpn_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q, count_d;
  always_comb count_d = clear ? '0 : (inc && !(&count_q)) ? count_q + WIDTH'(1) : count_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/kpn_split_scheduler.sv
// kpn_split_scheduler: moves one input token to two output FIFOs with blocking-write semantics.
module kpn_split_scheduler
  import kpn_pkg::*;
#(
  parameter int DATA_WIDTH = KPN_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  in_empty,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_rd,
  input  logic                  out1_full,
  input  logic                  out2_full,
  output logic                  out1_wr,
  output logic                  out2_wr,
  output logic [DATA_WIDTH-1:0] out1_data,
  output logic [DATA_WIDTH-1:0] out2_data,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  token_count,
  output logic [CNT_WIDTH-1:0]  stall_count
);
  kpn_split_state_t      state_q, state_d;
  logic [DATA_WIDTH-1:0] token_q, token_d;
  logic                  done1_q, done1_d, done2_q, done2_d;
  logic [CNT_WIDTH-1:0]  tok_cnt_q, tok_cnt_d;
  logic                  emit, fin, stall;
  always_comb begin
    emit      = state_q == EMIT;
    in_rd     = state_q == FETCH;
    busy      = state_q != IDLE;
    out1_wr   = emit && !done1_q && !out1_full;
    out2_wr   = emit && !done2_q && !out2_full;
    fin       = emit && (done1_q || out1_wr) && (done2_q || out2_wr);
    stall     = emit && ((!done1_q && out1_full) || (!done2_q && out2_full));
    state_d   = state_q;
    token_d   = token_q;
    done1_d   = done1_q | out1_wr;
    done2_d   = done2_q | out2_wr;
    tok_cnt_d = fin ? tok_cnt_q + CNT_WIDTH'(1) : tok_cnt_q;
    case (state_q)
      IDLE:  state_d = (enable && !in_empty) ? FETCH : IDLE;
      FETCH: state_d = LATCH;
      LATCH: begin
        state_d = EMIT;
        token_d = in_data;
        done1_d = 1'b0;
        done2_d = 1'b0;
      end
      default: state_d = fin ? IDLE : EMIT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      token_q   <= '0;
      done1_q   <= 1'b0;
      done2_q   <= 1'b0;
      tok_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      token_q   <= token_d;
      done1_q   <= done1_d;
      done2_q   <= done2_d;
      tok_cnt_q <= tok_cnt_d;
    end
  kpn_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall),
    .clear (1'b0),
    .count (stall_count)
  );
  assign out1_data   = token_q;
  assign out2_data   = token_q;
  assign token_count = tok_cnt_q;
endmodule

// File: tb/tb_kpn_split_scheduler.sv
// tb_kpn_split_scheduler: directed table, corner sequences and a randomized model check.
module tb_kpn_split_scheduler;
  localparam int CW = 4;
  logic clk = 0, rst_n = 0, enable = 0, out1_full = 0, out2_full = 0;
  logic in_empty, in_rd, out1_wr, out2_wr, busy;
  logic [15:0] in_data = 0, out1_data, out2_data;
  logic [CW-1:0] token_count, stall_count;
  int total = 0, bad = 0, cyc = 0, wp = 0, rp = 0;
  logic [15:0] mem [4096];
  logic [15:0] cap1 [$], cap2 [$];
  int rd_cyc [$];

  kpn_split_scheduler #(.DATA_WIDTH(16), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_empty(in_empty), .in_data(in_data),
    .in_rd(in_rd), .out1_full(out1_full), .out2_full(out2_full), .out1_wr(out1_wr),
    .out2_wr(out2_wr), .out1_data(out1_data), .out2_data(out2_data), .busy(busy),
    .token_count(token_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;
  assign in_empty = (wp == rp);
  // Input FIFO: read data shows up the cycle after in_rd; junk otherwise so a mistimed latch is visible.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    in_data <= (in_rd && wp != rp) ? mem[rp % 4096] : 16'($urandom);
    if (in_rd && wp != rp) rp <= rp + 1;
  end
  always @(negedge clk) if (rst_n) begin
    if (out1_wr) cap1.push_back(out1_data);
    if (out2_wr) cap2.push_back(out2_data);
    if (in_rd) rd_cyc.push_back(cyc);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic push(input logic [15:0] v);
    mem[wp % 4096] = v;
    wp++;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_tc(input logic [CW-1:0] t, input int bound, input string nm);
    int n = 0;
    while (token_count !== t && n < bound) begin
      step();
      n++;
    end
    chk(nm, 32'(token_count), 32'(t));
  endtask

  typedef struct {
    bit push; logic [15:0] pv; bit en, f1, f2, rd, w1, w2, bz;
    logic [15:0] d; logic [CW-1:0] tc, sc;
  } vec_t;
  vec_t tv [15];

  bit go_q, out_st, p1, p2, idle, e, ew1, ew2;
  int emit_at, idle_from, mc, ms;
  logic [15:0] tok;

  initial begin
    tv[0]  = '{1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0};
    tv[2]  = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    tv[3]  = '{0, 0, 1, 0, 0, 0, 1, 1, 1, 10, 0, 0};
    tv[4]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    tv[5]  = '{1, 50, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0};
    tv[6]  = '{0, 0, 1, 0, 1, 1, 0, 0, 1, 0, 1, 0};
    tv[7]  = '{0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 1, 0};
    tv[8]  = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 50, 1, 0};
    tv[9]  = '{0, 0, 1, 0, 1, 0, 0, 0, 1, 50, 1, 1};
    tv[10] = '{0, 0, 1, 0, 1, 0, 0, 0, 1, 50, 1, 2};
    tv[11] = '{0, 0, 1, 0, 1, 0, 0, 0, 1, 50, 1, 3};
    tv[12] = '{0, 0, 1, 0, 1, 0, 0, 0, 1, 50, 1, 4};
    tv[13] = '{0, 0, 1, 0, 0, 0, 0, 1, 1, 50, 1, 5};
    tv[14] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 5};
    #1;
    chk("reset_outputs", {busy, in_rd, out1_wr, out2_wr, out1_data, token_count, stall_count}, 0);
    repeat (2) step();
    rst_n = 1;
    enable = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_no_traffic", {busy, in_rd, out1_wr, out2_wr, token_count, stall_count}, 0);
    end
    step();
    foreach (tv[i]) begin
      if (tv[i].push) push(tv[i].pv);
      enable = tv[i].en;
      out1_full = tv[i].f1;
      out2_full = tv[i].f2;
      @(negedge clk);
      chk($sformatf("row%0d_strobes", i), {in_rd, out1_wr, out2_wr, busy}, {tv[i].rd, tv[i].w1, tv[i].w2, tv[i].bz});
      chk($sformatf("row%0d_counts", i), {token_count, stall_count}, {tv[i].tc, tv[i].sc});
      if (tv[i].d != 0) chk($sformatf("row%0d_data", i), {out1_data, out2_data}, {tv[i].d, tv[i].d});
      step();
    end
    chk("no_dup_out1", cap1.size(), 2);
    chk("no_dup_out2", cap2.size(), 2);

    cap1.delete(); cap2.delete(); rd_cyc.delete();
    push(10); push(50); push(90);
    wait_tc(5, 40, "b2b_token_count");
    chk("b2b_reads", rd_cyc.size(), 3);
    if (rd_cyc.size() == 3) chk("b2b_spacing", {rd_cyc[1] - rd_cyc[0], rd_cyc[2] - rd_cyc[1]}, {32'd4, 32'd4});
    chk("b2b_out1", cap1.size() == 3 ? {cap1[0], cap1[1], cap1[2]} : 0, {16'd10, 16'd50, 16'd90});
    chk("b2b_out2", cap2.size() == 3 ? {cap2[0], cap2[1], cap2[2]} : 0, {16'd10, 16'd50, 16'd90});

    cap1.delete(); cap2.delete();
    out2_full = 1;
    push(77);
    for (int n = 0; n < 10 && cap1.size() == 0; n++) step();
    chk("rst_pre_out1", cap1.size(), 1);
    out2_full = 0;
    rst_n = 0;
    #1;
    chk("rst_async_outputs", {busy, in_rd, out1_wr, out2_wr, out1_data, out2_data, token_count, stall_count}, 0);
    step();
    rst_n = 1;
    push(33);
    wait_tc(1, 20, "rst_refetch_count");
    chk("rst_out1", cap1.size() == 2 ? {cap1[0], cap1[1]} : 0, {16'd77, 16'd33});
    chk("rst_out2", cap2.size() == 1 ? 32'(cap2[0]) : 32'hdead, 33);

    cap1.delete(); cap2.delete();
    out1_full = 1;
    push(5);
    repeat (22) step();
    chk("stall_saturate", stall_count, {CW{1'b1}});
    enable = 0;
    repeat (2) step();
    chk("busy_after_disable", busy, 1);
    out1_full = 0;
    push(6);
    rd_cyc.delete();
    repeat (10) step();
    chk("disable_no_read", rd_cyc.size(), 0);
    chk("disable_completes", {busy, token_count}, {1'b0, CW'(2)});
    chk("disable_outs", (cap1.size() == 1 && cap2.size() == 1) ? {cap1[0], cap2[0]} : 0, {16'd5, 16'd5});
    enable = 1;
    for (int i = 0; i < 12; i++) push(16'(100 + i));
    wait_tc({CW{1'b1}}, 80, "tc_all_ones");
    push(99);
    wait_tc(0, 20, "tc_wrap");
    chk("stall_held", stall_count, {CW{1'b1}});

    rst_n = 0;
    wp = rp;
    enable = 0; out1_full = 0; out2_full = 0;
    step();
    rst_n = 1;
    go_q = 0; out_st = 0; p1 = 0; p2 = 0; idle_from = 0; mc = 0; ms = 0; emit_at = 0; tok = 0;
    for (int c = 0; c < 3000; c++) begin
      enable = $urandom_range(0, 9) < 8;
      out1_full = $urandom_range(0, 9) < 3;
      out2_full = $urandom_range(0, 9) < 3;
      if (wp - rp < 4 && $urandom_range(0, 9) < 4) push(16'($urandom));
      @(negedge clk);
      chk("rnd_in_rd", in_rd, go_q);
      chk("rnd_counts", {token_count, stall_count}, {CW'(mc), CW'(ms)});
      if (go_q) begin
        out_st = 1; emit_at = c + 2; p1 = 1; p2 = 1;
        tok = mem[rp % 4096];
      end
      idle = !out_st && c >= idle_from;
      chk("rnd_busy", busy, !idle);
      e = out_st && c >= emit_at;
      ew1 = e && p1 && !out1_full;
      ew2 = e && p2 && !out2_full;
      chk("rnd_wr", {out1_wr, out2_wr}, {ew1, ew2});
      if (e) begin
        chk("rnd_data", {out1_data, out2_data}, {tok, tok});
        if ((p1 && out1_full) || (p2 && out2_full)) ms = (ms < (1 << CW) - 1) ? ms + 1 : ms;
        p1 = p1 && !ew1;
        p2 = p2 && !ew2;
        if (!p1 && !p2) begin
          out_st = 0;
          idle_from = c + 1;
          mc = (mc + 1) % (1 << CW);
        end
      end
      go_q = idle && enable && !in_empty;
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
